// File: rtl/mem_arbiter.sv
// Memory-port arbiter that shares one memory port between the fetch requester and the data requester.
// Data wins ties. A streak counter forces a fetch grant after MAX_D_STREAK data grants.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_wmask,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  localparam logic [3:0] STREAK_LIM = 4'(MAX_D_STREAK);

  state_t     state;
  logic [3:0] d_streak;
  logic       d_pend, d_win;

  assign d_pend = d_read | d_write;
  assign d_win  = d_pend & (~i_read | (d_streak < STREAK_LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      d_streak    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_win) begin
            state       <= SERVE_D;
            mem_address <= d_address;
            mem_wdata   <= d_wdata;
            mem_wmask   <= d_wmask;
            // read+write together is illegal; resolve it as a write
            mem_read    <= d_read & ~d_write;
            mem_write   <= d_write;
            if (!i_read)
              d_streak <= '0;
            else if (d_streak != 4'hF)
              d_streak <= d_streak + 4'd1;
          end else if (i_read) begin
            state       <= SERVE_I;
            mem_address <= i_address;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            d_streak    <= '0;
          end
        end
        default: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
      endcase
    end
  end

  assign i_resp  = mem_resp & (state == SERVE_I);
  assign d_resp  = mem_resp & (state == SERVE_D);
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses and memory commands are queued at issue.
// Separate monitor and memory-responder processes pop the queues and compare.
module tb_mem_arbiter;
  logic        clk, rst_n;
  logic        i_read, d_read, d_write;
  logic [15:0] i_address, d_address, d_wdata;
  logic [1:0]  d_wmask;
  logic [15:0] i_rdata, d_rdata;
  logic        i_resp, d_resp;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic [1:0]  mem_wmask;
  logic        mem_resp_r, mem_resp_x;
  logic        busy;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  wmask;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [15:0] exp_i[$];
  logic [15:0] exp_d[$];
  int          tests = 0, fails = 0;
  int          n_iresp = 0, n_dresp = 0;
  int          lat = 1;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp_r | mem_resp_x), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_lookup(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1234 : ~a;
  endfunction

  // Memory model: checks each new command against the expected grant order, then answers after lat cycles
  initial begin
    cmd_t c;
    mem_resp_r = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_read || mem_write)) begin
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", {mem_read, mem_write, mem_wmask, mem_address, mem_wdata}, 64'h0);
        end else begin
          c = exp_cmd.pop_front();
          chk("cmd", {mem_read, mem_write, mem_wmask, mem_address, mem_wdata}, c);
        end
        repeat (lat) @(posedge clk);
        #1;
        if (mem_read || mem_write) begin
          mem_resp_r = 1'b1;
          mem_rdata  = mem_write ? 16'h0000 : mem_lookup(mem_address);
          @(posedge clk);
          #1;
          mem_resp_r = 1'b0;
          mem_rdata  = '0;
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_resp && d_resp) chk("both_resp", 1, 0);
      if (i_resp) begin
        n_iresp++;
        if (exp_i.size() == 0) chk("i_resp_unexpected", {16'h0, i_rdata}, 64'h1_0000);
        else chk("i_rdata", i_rdata, exp_i.pop_front());
      end else chk("i_rdata_quiet", i_rdata, 0);
      if (d_resp) begin
        n_dresp++;
        if (exp_d.size() == 0) chk("d_resp_unexpected", {16'h0, d_rdata}, 64'h1_0000);
        else chk("d_rdata", d_rdata, exp_d.pop_front());
      end else chk("d_rdata_quiet", d_rdata, 0);
    end
  end

  task automatic wait_resp_i();
    bit got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (i_resp) begin got = 1; break; end
    end
    if (!got) chk("i_resp_timeout", 0, 1);
    @(posedge clk); #1;
    i_read = 1'b0;
    @(negedge clk);
    chk("busy_after_i", busy, 0);
  endtask

  task automatic wait_resp_d();
    bit got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d_resp) begin got = 1; break; end
    end
    if (!got) chk("d_resp_timeout", 0, 1);
    @(posedge clk); #1;
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    chk("busy_after_d", busy, 0);
  endtask

  task automatic req_i(input logic [15:0] a, input logic [15:0] exp);
    exp_i.push_back(exp);
    i_address = a;
    i_read    = 1'b1;
    wait_resp_i();
  endtask

  task automatic req_d(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] wm, input logic [15:0] exp);
    exp_d.push_back(exp);
    d_address = a;
    d_wdata   = wd;
    d_wmask   = wm;
    d_read    = rd;
    d_write   = wr;
    wait_resp_d();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] streak_exp [8] = '{16'hBFFF, 16'hBFFE, 16'hBFFD, 16'hBFFC,
                                  16'hBFFB, 16'hBFFA, 16'hBFF9, 16'hBFF8};
  int r0;

  initial begin
    rst_n = 1'b0; mem_resp_x = 1'b0;
    i_read = 1'b1; i_address = 16'h0010;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0; d_wmask = '0;

    // Reset with a fetch already requested
    repeat (3) @(negedge clk);
    chk("rst_strobes", {mem_read, mem_write, busy, i_resp, d_resp}, 0);
    chk("rst_fields", {mem_address, mem_wdata, mem_wmask}, 0);
    lat = 2;
    exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000});
    exp_i.push_back(16'hFFEF);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_read", {mem_read, mem_address}, {1'b1, 16'h0010});
    wait_resp_i();

    // Single fetch, 3-cycle memory
    lat = 3;
    exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000});
    req_i(16'h0040, 16'h1234);

    // mem_resp while idle is ignored
    r0 = n_iresp + n_dresp;
    @(posedge clk); #1; mem_resp_x = 1'b1;
    @(posedge clk); #1; mem_resp_x = 1'b0;
    @(negedge clk);
    chk("idle_resp_busy", busy, 0);
    chk("idle_resp_count", n_iresp + n_dresp, r0);

    // Simultaneous fetch and write: data first
    lat = 2;
    exp_cmd.push_back('{1'b0, 1'b1, 2'b01, 16'h2000, 16'hBEEF});
    exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h0100, 16'h0000});
    fork
      req_i(16'h0100, 16'hFEFF);
      req_d(1'b1 & 1'b0, 1'b1, 16'h2000, 16'hBEEF, 2'b01, 16'h0000);
    join

    // Starvation guard: 4 D, I, 4 D, I
    lat = 1;
    for (int k = 0; k < 4; k++) exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h4000 + 16'(k), 16'h0000});
    exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h0200, 16'h0000});
    for (int k = 4; k < 8; k++) exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h4000 + 16'(k), 16'h0000});
    exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h0202, 16'h0000});
    fork
      for (int k = 0; k < 8; k++) req_d(1'b1, 1'b0, 16'h4000 + 16'(k), 16'h0, 2'b00, streak_exp[k]);
      begin
        req_i(16'h0200, 16'hFDFF);
        req_i(16'h0202, 16'hFDFD);
      end
    join

    // Request input change mid-transaction
    lat = 4;
    exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h3000, 16'h0000});
    exp_d.push_back(16'hCFFF);
    d_wdata = '0; d_wmask = '0; d_address = 16'h3000; d_read = 1'b1;
    @(posedge clk); #1;
    d_address = 16'h5555;
    @(negedge clk);
    chk("hold_addr_1", mem_address, 16'h3000);
    @(negedge clk);
    chk("hold_addr_2", mem_address, 16'h3000);
    wait_resp_d();

    // Read and write together resolves as a write
    lat = 1;
    exp_cmd.push_back('{1'b0, 1'b1, 2'b11, 16'h0700, 16'h1111});
    req_d(1'b1, 1'b1, 16'h0700, 16'h1111, 2'b11, 16'h0000);

    // Reset in the middle of a fetch: no response, strobes drop at once
    lat = 6;
    exp_cmd.push_back('{1'b1, 1'b0, 2'b00, 16'h0300, 16'h0000});
    i_address = 16'h0300; i_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    r0 = n_iresp;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async", {mem_read, busy, mem_address}, 0);
    i_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_resp", n_iresp, r0);
    chk("abort_idle", busy, 0);

    chk("exp_cmd_empty", exp_cmd.size(), 0);
    chk("exp_i_empty", exp_i.size(), 0);
    chk("exp_d_empty", exp_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
